// File: rtl/memory_access_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Holds FSM states, port ids, the request bundle and the arbitration pick.
// No timing of its own; consumed by the slot and the top.
package memory_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_RDATA = 2'd2
    } state_t;

    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    localparam logic [31:0] ADDR_NOP_DEFAULT = 32'hffff_ffff;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] wmask;
    } req_t;

    // With both ports pending, fair mode alternates away from the last winner.
    function automatic logic pick_port(input logic fair, input logic i_pend,
                                       input logic d_pend, input logic last_grant);
        if (i_pend && d_pend) begin
            return fair ? ~last_grant : PORT_DATA;
        end
        return d_pend ? PORT_DATA : PORT_INST;
    endfunction

endpackage

// File: rtl/memory_access_arbiter_request_slot.sv
// request_slot: one-entry request buffer in front of the arbiter.
// Latency: loads on start&ready, visible the next cycle; clears on retire.
// Backpressure: slot_rdy is low from the cycle after load until clear.
module request_slot
    import memory_access_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_wmask,
    output logic        slot_vld,
    output logic        slot_rdy,
    output logic [31:0] slot_addr,
    output logic        slot_write,
    output logic [31:0] slot_wdata,
    output logic [31:0] slot_wmask
);

    req_t slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= 1'b0;
            slot_q   <= '0;
        end else if (clear) begin
            slot_vld <= 1'b0;
        end else if (load && !slot_vld) begin
            slot_vld <= 1'b1;
            slot_q   <= '{addr: req_addr, write: req_write, wdata: req_wdata, wmask: req_wmask};
        end
    end

    assign slot_rdy   = !slot_vld;
    assign slot_addr  = slot_q.addr;
    assign slot_write = slot_q.write;
    assign slot_wdata = slot_q.wdata;
    assign slot_wmask = slot_q.wmask;

endmodule

// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter: shares one unaligned memory controller port between fetch and data.
// Latency: 1 cycle arbitration, then issue; read data returned 1 cycle after mem_rdata_valid.
// Backpressure: each port holds one request (cmd_ready low until retired); ISSUE holds on mem_cmd_ready.
module memory_access_arbiter
    import memory_access_arbiter_pkg::*;
#(
    parameter int          FAIR     = 1,
    parameter logic [31:0] ADDR_NOP = ADDR_NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_start,
    output logic        i_cmd_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_rdata_valid,
    input  logic        d_cmd_start,
    input  logic        d_cmd_write,
    output logic        d_cmd_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [31:0] d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_rdata_valid,
    output logic        mem_cmd_start,
    output logic        mem_cmd_write,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid
);

    logic        i_vld, d_vld;
    logic        i_clear, d_clear;
    logic [31:0] i_s_addr, i_s_wdata, i_s_wmask;
    logic [31:0] d_s_addr, d_s_wdata, d_s_wmask;
    logic        i_s_write, d_s_write;
    req_t        i_slot, d_slot, cur;

    state_t      state, state_nxt;
    logic        sel, sel_nxt;
    logic        last_grant, last_grant_nxt;
    logic        retire;
    logic        i_pulse_nxt, d_pulse_nxt;

    // Fetch is read-only, so its slot never carries write data.
    request_slot u_i_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (i_cmd_start & i_cmd_ready),
        .clear      (i_clear),
        .req_addr   (i_addr),
        .req_write  (1'b0),
        .req_wdata  (32'h0),
        .req_wmask  (32'h0),
        .slot_vld   (i_vld),
        .slot_rdy   (i_cmd_ready),
        .slot_addr  (i_s_addr),
        .slot_write (i_s_write),
        .slot_wdata (i_s_wdata),
        .slot_wmask (i_s_wmask)
    );

    request_slot u_d_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (d_cmd_start & d_cmd_ready),
        .clear      (d_clear),
        .req_addr   (d_addr),
        .req_write  (d_cmd_write),
        .req_wdata  (d_wdata),
        .req_wmask  (d_wmask),
        .slot_vld   (d_vld),
        .slot_rdy   (d_cmd_ready),
        .slot_addr  (d_s_addr),
        .slot_write (d_s_write),
        .slot_wdata (d_s_wdata),
        .slot_wmask (d_s_wmask)
    );

    assign i_slot = '{addr: i_s_addr, write: i_s_write, wdata: i_s_wdata, wmask: i_s_wmask};
    assign d_slot = '{addr: d_s_addr, write: d_s_write, wdata: d_s_wdata, wmask: d_s_wmask};
    assign cur    = (sel == PORT_DATA) ? d_slot : i_slot;

    assign i_clear = retire && (sel == PORT_INST);
    assign d_clear = retire && (sel == PORT_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sel           <= PORT_INST;
            last_grant    <= PORT_INST;
            i_rdata_valid <= 1'b0;
            d_rdata_valid <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
        end else begin
            state         <= state_nxt;
            sel           <= sel_nxt;
            last_grant    <= last_grant_nxt;
            i_rdata_valid <= i_pulse_nxt;
            d_rdata_valid <= d_pulse_nxt;
            if (i_pulse_nxt) begin
                i_rdata <= mem_rdata;
            end
            if (d_pulse_nxt) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        last_grant_nxt = last_grant;
        retire         = 1'b0;
        i_pulse_nxt    = 1'b0;
        d_pulse_nxt    = 1'b0;
        mem_cmd_start  = 1'b0;
        mem_cmd_write  = 1'b0;
        mem_addr       = ADDR_NOP;
        mem_wdata      = '0;
        mem_wmask      = '0;

        case (state)
            ST_IDLE: begin
                if (i_vld || d_vld) begin
                    sel_nxt        = pick_port(FAIR != 0, i_vld, d_vld, last_grant);
                    last_grant_nxt = sel_nxt;
                    state_nxt      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_addr      = cur.addr;
                mem_cmd_write = cur.write;
                mem_wdata     = cur.wdata;
                mem_wmask     = cur.wmask;
                mem_cmd_start = mem_cmd_ready;
                if (mem_cmd_ready) begin
                    // Stores are posted: the slot frees as soon as downstream takes it.
                    if (cur.write) begin
                        retire    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_WAIT_RDATA;
                    end
                end
            end
            ST_WAIT_RDATA: begin
                mem_addr = cur.addr;
                if (mem_rdata_valid) begin
                    retire      = 1'b1;
                    i_pulse_nxt = (sel == PORT_INST);
                    d_pulse_nxt = (sel == PORT_DATA);
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/memory_access_arbiter.md
Name: memory_access_arbiter

Overview:
Shares the single unaligned-access memory controller port between the instruction-fetch requester (read-only) and the data load/store requester. Each requester gets its own start/ready/rdata/valid handshake, backed by a one-entry request slot. A round-robin (or fixed-priority) scheduler serialises the slots onto the downstream command interface. Sits between the CPU fetch/memory stages and the unaligned-access controller.

Parameters:
FAIR, 1, 1 = round-robin between ports when both are pending; 0 = data port always wins.
ADDR_NOP, 32'hffffffff, value driven on mem_addr when no command is being presented.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_cmd_start  in  1  fetch request strobe; accepted when i_cmd_ready=1
i_cmd_ready  out  1  fetch slot empty
i_addr  in  32  fetch byte address; any alignment
i_rdata  out  32  fetch read data
i_rdata_valid  out  1  one-cycle pulse; i_rdata valid
d_cmd_start  in  1  data request strobe; accepted when d_cmd_ready=1
d_cmd_write  in  1  1 = store, 0 = load
d_cmd_ready  out  1  data slot empty
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_wmask  in  32  store bit mask
d_rdata  out  32  load data
d_rdata_valid  out  1  one-cycle pulse; d_rdata valid
mem_cmd_start  out  1  downstream command strobe
mem_cmd_write  out  1  downstream write flag
mem_cmd_ready  in  1  downstream idle/accepting
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_wmask  out  32  downstream write mask
mem_rdata  in  32  downstream read data
mem_rdata_valid  in  1  downstream read-data pulse

Behaviour:
- Single clock clk. rst_n is asynchronous and active-low. On reset: slots empty, i/d_cmd_ready=1, i/d_rdata_valid=0, i/d_rdata=0, FSM=IDLE, mem_cmd_start=0, mem_cmd_write=0, mem_addr=ADDR_NOP, mem_wdata=0, mem_wmask=0, last_grant=INST (so data wins the first tie).
- Slots: start&ready at edge N latches addr/write/wdata/wmask; ready=0 from N+1 until the request retires. Fetch slot write flag is forced to 0.
- FSM states: IDLE, ISSUE, WAIT_RDATA.
- IDLE: if any slot is pending, select a port. With FAIR=1 and both pending, choose the port opposite last_grant; otherwise choose the pending port (FAIR=0: data first). Record the selection in sel and last_grant, then go to ISSUE. Each arbitration decision costs one cycle.
- ISSUE: drive mem_addr/mem_cmd_write/mem_wdata/mem_wmask combinationally from slot[sel]. mem_cmd_start = mem_cmd_ready. Hold until mem_cmd_ready=1.
  - On accept of a write: posted. Clear the data slot (d_cmd_ready=1 next cycle) and go to IDLE. The downstream ready drops by itself next cycle, and the next ISSUE waits for it.
  - On accept of a read: go to WAIT_RDATA.
- WAIT_RDATA: mem_addr holds the slot address, mem_cmd_start=0. On mem_rdata_valid: register mem_rdata into the sel port's rdata, pulse that port's rdata_valid for exactly one cycle (one-cycle latency after mem_rdata_valid), clear the slot, go to IDLE.
- Outside ISSUE/WAIT_RDATA, outputs take their reset-idle values. rdata holds its last value between pulses.
- Ready and valid coincide: i/d_cmd_ready=1 in the same cycle as the port's rdata_valid pulse, and a new start in that cycle is accepted.
- mem_rdata_valid outside WAIT_RDATA is ignored. This covers a stale response after reset.
- Reset mid-operation: all state clears immediately. Any in-flight downstream op is abandoned from the arbiter's view, and its late valid is ignored. ISSUE waits on mem_cmd_ready, so no new command is issued until the downstream returns to idle.
- Starvation: with FAIR=1, each port waits at most one other transaction.

Decomposition:
- Shared package: FSM state localparams (IDLE/ISSUE/WAIT_RDATA), port id constants PORT_INST/PORT_DATA, ADDR_NOP default.
- One sub-module: request_slot (one-entry buffer: valid, addr, write, wdata, wmask; load/clear; ready=!valid), instantiated twice.

Test Plan:
- Fetch read 0x100, mem model returns 0x00000013 after 3 cycles -> i_rdata_valid single pulse with i_rdata=0x00000013 one cycle after mem_rdata_valid; i_cmd_ready low throughout, high in the pulse cycle.
- Store d_addr=0x8, wdata=0xdeadbeef, wmask=0xffffffff -> one mem_cmd_start with mem_cmd_write=1, addr 0x8, wdata 0xdeadbeef; d_cmd_ready=1 the cycle after accept; no d_rdata_valid.
- Fetch and load (0x4) started in the same cycle, FAIR=1, after reset -> data issued first, then fetch; next simultaneous pair -> fetch first. With FAIR=0 -> data first both times.
- Unaligned load 0x5 while mem_cmd_ready held low 10 cycles -> mem_cmd_start asserted only on the cycle ready=1, addr 0x5 stable throughout ISSUE; d_rdata=0xefcafebe for memory words 0xcafebebe/0xdeadbeef.
- rst_n pulsed low during WAIT_RDATA, then stray mem_rdata_valid -> no rdata_valid on either port; both ready=1; mem_addr=0xffffffff.
- Back-to-back: new d_cmd_start in the d_rdata_valid cycle -> accepted, and a second downstream command issued once mem_cmd_ready=1.
